// File: rtl/systolic_feeder.sv
// Operand staging and diagonal-skew feeder for an NxN systolic PE array.
// Optional macro FEEDER_KEEP_EN: retain the loaded tile across DONE so start can replay it.
module systolic_feeder #(
   parameter int WIDTH = 8,
   parameter int N     = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 start,
   output logic [N*WIDTH-1:0]   a_feed,
   output logic [N*WIDTH-1:0]   b_feed,
   output logic                 pe_clear,
   output logic                 busy,
   output logic                 done
);

   localparam int NN   = N * N;
   localparam int TOT  = 2 * NN;
   localparam int CW   = $clog2(TOT + 1);
   localparam int BW   = $clog2(TOT);
   localparam int SW   = $clog2(3 * N);
   localparam int LAST = 3 * N - 3;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CLEAR  = 2'd1,
      S_STREAM = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t             r_state;
   logic [CW-1:0]      r_cnt;
   logic [SW-1:0]      r_step;
   logic [WIDTH-1:0]   r_buf [0:(2**BW)-1];

   logic               w_full;
   logic               w_load;
   logic [SW-1:0]      w_nstep;
   logic [N*WIDTH-1:0] w_a_next;
   logic [N*WIDTH-1:0] w_b_next;

   assign w_full   = (r_cnt == CW'(TOT));
   assign in_ready = (r_state == S_IDLE) && (r_cnt < CW'(TOT));
   assign w_load   = in_valid && in_ready;

   // Step whose lanes are registered at the coming edge: 0 while in CLEAR, s+1 while streaming.
   assign w_nstep  = (r_state == S_STREAM) ? (r_step + SW'(1)) : SW'(0);

   // Tile buffer: A occupies words 0..NN-1, B words NN..2NN-1, both row-major.
   always_ff @(posedge clk) begin
      if (w_load) begin
         r_buf[r_cnt[BW-1:0]] <= in_data;
      end
   end

   // Skewed lane selection for step w_nstep; out-of-window and drain lanes are zero.
   always_comb begin
      w_a_next = '0;
      w_b_next = '0;
      for (int i = 0; i < N; i++) begin
         int k;
         k = int'(w_nstep) - i;
         if ((k >= 0) && (k < N)) begin
            w_a_next[i*WIDTH +: WIDTH] = r_buf[BW'(i * N + k)];
            w_b_next[i*WIDTH +: WIDTH] = r_buf[BW'(NN + k * N + i)];
         end else begin
            w_a_next[i*WIDTH +: WIDTH] = '0;
            w_b_next[i*WIDTH +: WIDTH] = '0;
         end
      end
   end

   // Control FSM with registered feeds and status outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_step   <= '0;
         a_feed   <= '0;
         b_feed   <= '0;
         pe_clear <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               done <= 1'b0;
               if (w_load) begin
                  r_cnt <= r_cnt + CW'(1);
               end
               // w_full reflects the count before this edge, so a start alongside the last word is dropped.
               if (start && w_full) begin
                  r_state  <= S_CLEAR;
                  pe_clear <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            S_CLEAR: begin
               r_state  <= S_STREAM;
               r_step   <= '0;
               pe_clear <= 1'b0;
               a_feed   <= w_a_next;
               b_feed   <= w_b_next;
            end
            S_STREAM: begin
               if (r_step == SW'(LAST)) begin
                  r_state <= S_DONE;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  a_feed  <= '0;
                  b_feed  <= '0;
               end else begin
                  r_step  <= r_step + SW'(1);
                  a_feed  <= w_a_next;
                  b_feed  <= w_b_next;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               done    <= 1'b0;
`ifdef FEEDER_KEEP_EN
               r_cnt   <= r_cnt;
`else
               r_cnt   <= '0;
`endif
            end
            default: begin
               r_state  <= S_IDLE;
               r_cnt    <= '0;
               a_feed   <= '0;
               b_feed   <= '0;
               pe_clear <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule
